// File: rtl/vote_session_ctrl.sv
// Session controller and round-robin booth arbiter for the VoterPlus weighted vote counter.
// Optional OPEN-phase timeout is enabled by defining VOTE_SESSION_TIMEOUT_EN.
module vote_session_ctrl #(
    parameter int NREQ         = 4,
    parameter int SETTLE_CYC   = 2,
    parameter int OPEN_TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                close,
    input  logic [NREQ-1:0]     bq_valid,
    input  logic [2*NREQ-1:0]   bq_class,
    input  logic [5*NREQ-1:0]   bq_id,
    output logic [NREQ-1:0]     bq_ready,
    output logic                ack_valid,
    output logic [2:0]          ack_booth,
    output logic                ack_reject,
    output logic                vp_reset,
    output logic [31:0]         vp_np,
    output logic [7:0]          vp_vip,
    output logic                vp_vvip,
    input  logic [7:0]          vp_result,
    output logic [7:0]          final_result,
    output logic [5:0]          ballots,
    output logic                busy,
    output logic                done
`ifdef VOTE_SESSION_TIMEOUT_EN
    ,
    output logic                timed_out
`endif
);

    localparam int         PW          = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int         CW          = $clog2(SETTLE_CYC + 1);
    localparam logic [5:0] LAST_BALLOT = 6'd40;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_OPEN,
        S_SETTLE,
        S_DONE
    } state_e;

    if (NREQ < 2 || NREQ > 8 || SETTLE_CYC < 1 || SETTLE_CYC > 15 || OPEN_TIMEOUT < 2) begin : g_bad_param
        $error("vote_session_ctrl: parameter out of range");
    end

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [31:0]     np_q;
    logic [7:0]      vip_q;
    logic            vvip_q;
    logic [5:0]      ballots_q;
    logic [7:0]      final_q;
    logic [CW-1:0]   settle_q;
    logic            ack_valid_q, ack_reject_q, vp_reset_q, busy_q, done_q;
    logic [2:0]      ack_booth_q;

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt_oh;
    logic [1:0]      g_class;
    logic [4:0]      g_id;
    logic            g_legal, g_dup, accept;
    logic            timeout_hit;

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin
        int            j;
        logic [PW-1:0] jj;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        j       = 0;
        jj      = '0;
        if (state_q == S_OPEN) begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(ptr_q) + k;
                if (j >= NREQ) j = j - NREQ;
                jj = PW'(j);
                if (!gnt_any && bq_valid[jj]) begin
                    gnt_any = 1'b1;
                    gnt_idx = jj;
                end
            end
        end
        if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    end

    always_comb begin
        g_class = 2'd3;
        g_id    = '0;
        g_legal = 1'b0;
        g_dup   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == gnt_idx) begin
                g_class = bq_class[2*k +: 2];
                g_id    = bq_id[5*k +: 5];
            end
        end
        case (g_class)
            2'd0: begin
                g_legal = 1'b1;
                g_dup   = np_q[g_id];
            end
            2'd1: begin
                g_legal = (g_id < 5'd8);
                g_dup   = vip_q[g_id[2:0]];
            end
            2'd2: begin
                g_legal = (g_id == 5'd0);
                g_dup   = vvip_q;
            end
            default: g_legal = 1'b0;
        endcase
        accept = gnt_any && g_legal && !g_dup;
    end

`ifdef VOTE_SESSION_TIMEOUT_EN
    localparam int TW = $clog2(OPEN_TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q;
    logic          timed_out_q;

    assign timeout_hit = (state_q == S_OPEN) && (to_cnt_q == TW'(OPEN_TIMEOUT - 1));
    assign timed_out   = timed_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else if (state_q == S_CLEAR) begin
            to_cnt_q    <= '0;
            timed_out_q <= 1'b0;
        end else if (state_q == S_OPEN) begin
            to_cnt_q <= to_cnt_q + 1'b1;
            if (timeout_hit) timed_out_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_OPEN;
            S_OPEN: begin
                if (close || timeout_hit || (accept && ballots_q == LAST_BALLOT))
                    state_d = S_SETTLE;
            end
            S_SETTLE: if (settle_q == CW'(1)) state_d = S_DONE;
            S_DONE:   if (start) state_d = S_CLEAR;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            np_q         <= '0;
            vip_q        <= '0;
            vvip_q       <= 1'b0;
            ballots_q    <= '0;
            final_q      <= '0;
            settle_q     <= '0;
            ack_valid_q  <= 1'b0;
            ack_booth_q  <= '0;
            ack_reject_q <= 1'b0;
            vp_reset_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            vp_reset_q   <= (state_d == S_CLEAR);
            busy_q       <= (state_d == S_CLEAR) || (state_d == S_OPEN) || (state_d == S_SETTLE);
            done_q       <= (state_d == S_DONE);
            ack_valid_q  <= gnt_any;
            ack_reject_q <= gnt_any && !accept;
            if (gnt_any) ack_booth_q <= 3'(gnt_idx);

            case (state_q)
                S_CLEAR: begin
                    np_q      <= '0;
                    vip_q     <= '0;
                    vvip_q    <= 1'b0;
                    ballots_q <= '0;
                    final_q   <= '0;
                    ptr_q     <= '0;
                end
                S_OPEN: begin
                    if (gnt_any)
                        ptr_q <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (accept) begin
                        ballots_q <= ballots_q + 6'd1;
                        case (g_class)
                            2'd0:    np_q[g_id]        <= 1'b1;
                            2'd1:    vip_q[g_id[2:0]]  <= 1'b1;
                            default: vvip_q            <= 1'b1;
                        endcase
                    end
                    if (state_d == S_SETTLE) settle_q <= CW'(SETTLE_CYC);
                end
                S_SETTLE: begin
                    settle_q <= settle_q - 1'b1;
                    if (state_d == S_DONE) final_q <= vp_result;
                end
                default: ;
            endcase
        end
    end

    assign bq_ready     = gnt_oh;
    assign ack_valid    = ack_valid_q;
    assign ack_booth    = ack_booth_q;
    assign ack_reject   = ack_reject_q;
    assign vp_reset     = vp_reset_q;
    assign vp_np        = np_q;
    assign vp_vip       = vip_q;
    assign vp_vvip      = vvip_q;
    assign final_result = final_q;
    assign ballots      = ballots_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
